ysyx_25040109_lsu: RTL
======================

Name: ysyx_25040109_lsu

Overview:
Load/store unit directly downstream of the execute stage.
- Takes the effective address and store data computed by execute, plus the load/store decode.
- Runs one memory transaction over a simple valid/ready request plus response-valid bus.
- Returns an aligned, sign- or zero-extended load value with the rd write-enable to writeback.
- Blocking, one outstanding access; execute stalls on `req_ready` = 0.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data bus width. Fixed at 32 for RV32; other values are unsupported.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute presents an access.
- req_ready  out  1  LSU accepts an access this cycle.
- req_is_load  in  1  opcode 0000011.
- req_is_store  in  1  opcode 0100011.
- req_funct3  in  3  access size and sign.
- req_addr  in  ADDR_W  effective address (ALU result).
- req_wdata  in  DATA_W  store data (rs2).
- req_rd  in  5  destination register.
- mem_req_valid  out  1  bus request.
- mem_req_ready  in  1  bus accepts the request.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  word-aligned address.
- mem_wdata  out  DATA_W  lane-positioned store data.
- mem_wmask  out  4  byte strobes.
- mem_rsp_valid  in  1  read data or write acknowledge.
- mem_rdata  in  DATA_W  read word.
- wb_valid  out  1  result available.
- wb_ready  in  1  writeback consumes the result.
- wb_we  out  1  write rd.
- wb_rd  out  5  destination register.
- wb_data  out  DATA_W  load result; 0 for stores.
- wb_err  out  1  misaligned access or illegal funct3.

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Registered state.
- Reset (async, `rst_n` low):
  - State goes to IDLE and all capture registers clear.
  - Outputs are all 0 except `req_ready` = 1.
  - Reset mid-transaction abandons the access; the memory side shares the reset.
- IDLE:
  - `req_ready` = 1; `req_ready` is 0 in every other state.
  - Accept = `req_valid` & `req_ready` & (`req_is_load` | `req_is_store`). On accept, capture addr, funct3, wdata, rd and type.
  - `req_valid` with neither type flag set: ignored, stay IDLE.
  - Both type flags set: treat as illegal → error path.
- Error check, evaluated at accept:
  - Halfword with addr[0] = 1 → error.
  - Word with addr[1:0] ≠ 0 → error.
  - Load funct3 in {011, 110, 111} → error.
  - Store funct3 not in {000, 001, 010} → error.
  - Error → DONE with `wb_err` = 1, `wb_we` = 0, `wb_data` = 0. No bus activity.
  - No error → REQ.
- REQ:
  - `mem_req_valid` = 1.
  - `mem_addr` = {addr[31:2], 2'b00}; `mem_we` = is_store.
  - All bus outputs held stable until `mem_req_ready`; then go to WAIT.
- Store lanes:
  - SB: mask 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: mask 0011 << {addr[1], 0}; wdata = {2{wdata[15:0]}}.
  - SW: mask 1111.
  - Loads drive mask 0000.
- WAIT:
  - On `mem_rsp_valid`, go to DONE.
  - Load: shift `mem_rdata` right by 8·addr[1:0], then extend:
    - LB: sign-extend bit 7.
    - LBU: zero-extend from bit 7.
    - LH: sign-extend bit 15.
    - LHU: zero-extend from bit 15.
    - LW: full word.
  - Store: rdata ignored.
  - `mem_rsp_valid` in any state other than WAIT is ignored.
  - No timeout; the bus guarantees a response.
- DONE:
  - `wb_valid` = 1; `wb_we`/`wb_rd`/`wb_data`/`wb_err` held stable.
  - Leave when `wb_ready` = 1, returning to IDLE.
  - `wb_valid` is 0 in all other states.
  - rd = 0 load: `wb_we` = 1 anyway; the register file discards the write.
- Latency:
  - Accept at cycle T; `mem_req_valid` at T+1.
  - With `mem_req_ready` at T+1 and `mem_rsp_valid` at T+2, `wb_valid` at T+3.
  - Error path: `wb_valid` at T+1.
- Throughput: back-to-back accept is possible the cycle after DONE → IDLE.

Decomposition:
- Shared package:
  - Opcode constants LOAD = 7'b0000011, STORE = 7'b0100011.
  - funct3 constants LB/LH/LW/LBU/LHU/SB/SH/SW.
  - LSU state enum, 2-bit.
- One combinational sub-module, ysyx_25040109_lsu_align:
  - Inputs: funct3, addr[1:0], store data, read word.
  - Outputs: wmask, positioned wdata, extended load data, misalign flag.
- The FSM and capture registers stay in the top.

Test Plan:
- LB: addr 0x80000003, `mem_rdata` 0x80FF7F01, one-cycle bus → `wb_data` 0xFFFFFF80, `wb_we` = 1, `wb_valid` three cycles after accept.
- LHU: addr 0x80000002, rdata 0x8001ABCD → `wb_data` 0x00008001. LH at the same address → 0xFFFF8001.
- SB: addr 0x80000001, wdata 0x123456AB → `mem_wmask` 0010, `mem_wdata` 0xABABABAB, `mem_we` = 1, `wb_we` = 0.
- SW: addr 0x80000006 → `wb_err` = 1 at T+1, `mem_req_valid` never asserted.
- Backpressure:
  - Hold `mem_req_ready` = 0 for 5 cycles → `mem_addr`/`mem_wdata`/`mem_wmask` stable throughout.
  - Hold `wb_ready` = 0 for 3 cycles → `wb_valid` stays high and `req_ready` stays 0.
  - Spurious `mem_rsp_valid` during REQ is ignored.
- Reset: assert `rst_n` low during WAIT → `mem_req_valid`/`wb_valid` = 0 and `req_ready` = 1 immediately (async). After release, a new LW completes normally.

Source files
------------

// File: rtl/ysyx_25040109_lsu_pkg.sv
// Shared constants, state encoding and access-legality helper for the load/store unit.
package ysyx_25040109_lsu_pkg;

    localparam int LSU_XLEN = 32;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_e;

    // Both type flags set is treated as an illegal encoding, like a bad funct3.
    function automatic logic lsu_access_err(input logic       is_load,
                                            input logic       is_store,
                                            input logic [2:0] funct3,
                                            input logic       misalign);
        logic err;
        err = 1'b0;
        if (is_load && is_store) begin
            err = 1'b1;
        end else if (is_load) begin
            err = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111) | misalign;
        end else if (is_store) begin
            err = (funct3 > F3_SW) | misalign;
        end else begin
            err = 1'b0;
        end
        return err;
    endfunction

endpackage

// File: rtl/ysyx_25040109_lsu_if.sv
// Memory-side request/response bus between the LSU (master) and memory (slave).
interface ysyx_25040109_lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/ysyx_25040109_lsu_align.sv
// Byte-lane steering for stores, load extraction/extension and misalignment detection.
module ysyx_25040109_lsu_align
    import ysyx_25040109_lsu_pkg::*;
(
    input  logic [2:0]          funct3,
    input  logic [1:0]          addr_lo,
    input  logic [LSU_XLEN-1:0] wdata,
    input  logic [LSU_XLEN-1:0] rdata,
    output logic [3:0]          wmask,
    output logic [LSU_XLEN-1:0] wdata_pos,
    output logic [LSU_XLEN-1:0] ldata,
    output logic                misalign
);

    logic [LSU_XLEN-1:0] shifted_s;

    // Size field funct3[1:0] drives alignment and store-lane placement.
    always_comb begin
        misalign  = 1'b0;
        wmask     = 4'b0000;
        wdata_pos = {LSU_XLEN{1'b0}};
        case (funct3[1:0])
            2'b00: begin
                wmask     = 4'b0001 << addr_lo;
                wdata_pos = {4{wdata[7:0]}};
            end
            2'b01: begin
                misalign  = addr_lo[0];
                wmask     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_pos = {2{wdata[15:0]}};
            end
            2'b10: begin
                misalign  = (addr_lo != 2'b00);
                wmask     = 4'b1111;
                wdata_pos = wdata;
            end
            default: begin
                misalign  = 1'b0;
                wmask     = 4'b0000;
                wdata_pos = {LSU_XLEN{1'b0}};
            end
        endcase
    end

    // Bring the addressed byte/halfword down to bit 0, then extend.
    always_comb begin
        shifted_s = rdata >> {addr_lo, 3'b000};
        ldata     = {LSU_XLEN{1'b0}};
        case (funct3)
            F3_LB:   ldata = {{24{shifted_s[7]}}, shifted_s[7:0]};
            F3_LBU:  ldata = {24'h000000, shifted_s[7:0]};
            F3_LH:   ldata = {{16{shifted_s[15]}}, shifted_s[15:0]};
            F3_LHU:  ldata = {16'h0000, shifted_s[15:0]};
            F3_LW:   ldata = shifted_s;
            default: ldata = {LSU_XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/ysyx_25040109_lsu.sv
// Blocking load/store unit: one outstanding access, results handed to writeback.
module ysyx_25040109_lsu
    import ysyx_25040109_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_is_load,
    input  logic                 req_is_store,
    input  logic [2:0]           req_funct3,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    input  logic [4:0]           req_rd,
    ysyx_25040109_lsu_if.master  mem,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic                 wb_we,
    output logic [4:0]           wb_rd,
    output logic [DATA_W-1:0]    wb_data,
    output logic                 wb_err
);

    lsu_state_e        state_r, state_nxt_s;
    logic [2:0]        f3_r;
    logic [1:0]        addr_lo_r;
    logic              is_load_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [3:0]        mem_wmask_r;
    logic              mem_we_r;
    logic              wb_we_r;
    logic [4:0]        wb_rd_r;
    logic [DATA_W-1:0] wb_data_r;
    logic              wb_err_r;

    logic [2:0]        align_f3_s;
    logic [1:0]        align_lo_s;
    logic [3:0]        wmask_s;
    logic [DATA_W-1:0] wdata_pos_s;
    logic [DATA_W-1:0] ldata_s;
    logic              misalign_s;
    logic              accept_s;
    logic              access_err_s;
    logic              store_ok_s;

    // In IDLE the aligner checks the incoming request; afterwards it serves the captured access.
    assign align_f3_s   = (state_r == ST_IDLE) ? req_funct3    : f3_r;
    assign align_lo_s   = (state_r == ST_IDLE) ? req_addr[1:0] : addr_lo_r;
    assign accept_s     = req_valid & req_ready & (req_is_load | req_is_store);
    assign access_err_s = lsu_access_err(req_is_load, req_is_store, req_funct3, misalign_s);
    assign store_ok_s   = req_is_store & ~req_is_load & ~access_err_s;

    ysyx_25040109_lsu_align u_align (
        .funct3    (align_f3_s),
        .addr_lo   (align_lo_s),
        .wdata     (req_wdata),
        .rdata     (mem.mem_rdata),
        .wmask     (wmask_s),
        .wdata_pos (wdata_pos_s),
        .ldata     (ldata_s),
        .misalign  (misalign_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; errors skip the bus entirely.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = access_err_s ? ST_DONE : ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ:  state_nxt_s = mem.mem_req_ready ? ST_WAIT : ST_REQ;
            ST_WAIT: state_nxt_s = mem.mem_rsp_valid ? ST_DONE : ST_WAIT;
            ST_DONE: state_nxt_s = wb_ready ? ST_IDLE : ST_DONE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        req_ready         = 1'b0;
        mem.mem_req_valid = 1'b0;
        wb_valid          = 1'b0;
        case (state_r)
            ST_IDLE: req_ready         = 1'b1;
            ST_REQ:  mem.mem_req_valid = 1'b1;
            ST_WAIT: wb_valid          = 1'b0;
            ST_DONE: wb_valid          = 1'b1;
            default: req_ready         = 1'b0;
        endcase
    end

    // Capture registers: bus fields at accept, load data at response, cleared after writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_r        <= 3'b000;
            addr_lo_r   <= 2'b00;
            is_load_r   <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            mem_wmask_r <= 4'b0000;
            mem_we_r    <= 1'b0;
            wb_we_r     <= 1'b0;
            wb_rd_r     <= 5'd0;
            wb_data_r   <= {DATA_W{1'b0}};
            wb_err_r    <= 1'b0;
        end else if (accept_s) begin
            f3_r        <= req_funct3;
            addr_lo_r   <= req_addr[1:0];
            is_load_r   <= req_is_load & ~req_is_store;
            mem_addr_r  <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_r <= store_ok_s ? wdata_pos_s : {DATA_W{1'b0}};
            mem_wmask_r <= store_ok_s ? wmask_s : 4'b0000;
            mem_we_r    <= store_ok_s;
            wb_we_r     <= req_is_load & ~req_is_store & ~access_err_s;
            wb_rd_r     <= req_rd;
            wb_data_r   <= {DATA_W{1'b0}};
            wb_err_r    <= access_err_s;
        end else if ((state_r == ST_WAIT) && mem.mem_rsp_valid) begin
            wb_data_r <= is_load_r ? ldata_s : {DATA_W{1'b0}};
        end else if ((state_r == ST_DONE) && wb_ready) begin
            wb_we_r   <= 1'b0;
            wb_rd_r   <= 5'd0;
            wb_data_r <= {DATA_W{1'b0}};
            wb_err_r  <= 1'b0;
        end
    end

    assign mem.mem_addr  = mem_addr_r;
    assign mem.mem_wdata = mem_wdata_r;
    assign mem.mem_wmask = mem_wmask_r;
    assign mem.mem_we    = mem_we_r;
    assign wb_we         = wb_we_r;
    assign wb_rd         = wb_rd_r;
    assign wb_data       = wb_data_r;
    assign wb_err        = wb_err_r;

endmodule
